fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage with an integrated IF/ID pipeline register. It owns the fetch PC and issues requests to instruction memory through a valid/ready handshake. It captures each response and presents the instruction, its PC and PC+4 to the decode stage. Bits instr_d[31:7] feed the immediate extend unit directly, and the control decoder drives immsrc from instr_d[6:0].

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  32  fetch address (word aligned, [1:0]=0)
- imem_rsp_valid  in  1  response valid, at earliest the cycle after acceptance
- imem_rsp_data  in  32  fetched instruction
- stall_d  in  1  hazard unit holds the decode register
- redirect  in  1  branch/jump taken, flush and refetch
- redirect_pc  in  32  new fetch target
- instr_d  out  32  decode-stage instruction
- pc_d  out  32  PC of instr_d
- pc_plus4_d  out  32  pc_d + 4
- valid_d  out  1  instr_d is a real instruction

## Operation
- State machine states:
  - RUN: no request outstanding.
  - WAIT: one request outstanding.
  - DROP: the outstanding response is stale and is discarded.
- At most one outstanding request. A one-entry hold buffer stores {instr, pc} when a response arrives while the decode register is stalled.
- imem_req_valid is high in these cases, and low while reset is high:
  - in RUN when the hold buffer is empty;
  - in WAIT in the cycle imem_rsp_valid arrives, if that response will not occupy the hold buffer.
- imem_addr is pc_f, the fetch PC.
- Request handshake (imem_req_valid & imem_req_ready):
  - pc_f is latched as req_pc.
  - pc_f advances by 4.
  - The next state is WAIT.
- Response handling in WAIT:
  - If the decode register is free (!stall_d | !valid_d), the decode register loads {imem_rsp_data, req_pc, req_pc+4} and valid_d=1.
  - Otherwise the response goes into the hold buffer.
  - The next state is RUN, or stays WAIT if a new request was accepted in the same cycle.
- Hold buffer drains into the decode register on the first cycle with stall_d=0. It has priority over any new response; none can arrive, because requests are blocked while the buffer is full.
- Decode register free with nothing to load: instr_d=NOP_INSTR, valid_d=0. pc_d and pc_plus4_d keep their values.
- stall_d=1 with valid_d=1: instr_d, pc_d, pc_plus4_d and valid_d hold.
- redirect (highest priority, overrides stall_d):
  - instr_d=NOP_INSTR and valid_d=0.
  - The hold buffer is cleared.
  - pc_f=redirect_pc.
  - If a request is outstanding, or one is accepted in the redirect cycle, the next state is DROP; otherwise RUN.
- DROP:
  - imem_req_valid=0.
  - The next imem_rsp_valid is discarded and the state moves to RUN.
  - A redirect while in DROP updates pc_f only.
- Arithmetic is 32-bit with wrap-around: 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset values:
  - pc_f=RESET_PC
  - state=RUN
  - hold buffer empty
  - instr_d=NOP_INSTR
  - pc_d=0, pc_plus4_d=0
  - valid_d=0
  - imem_req_valid=0
- First request: the cycle after reset deasserts.
- Latency: request accepted at cycle N, response at N+k (k≥1), instr_d valid at N+k+1.
- Throughput: with k=1 and imem_req_ready=1, one instruction per cycle.
- Redirect at cycle R: valid_d=0 at R+1.
  - With no request outstanding, the request to redirect_pc is issued at R+1.
  - Otherwise it is issued the cycle after the stale response.
- Reset mid-operation: all state returns to reset values next edge; an in-flight response is ignored.

## Structure
- Shared package fetch_pkg holds:
  - RESET_PC and NOP_INSTR defaults;
  - the fetch_state_t enum {RUN, WAIT, DROP};
  - the if_id_t struct {instr, pc, pc_plus4, valid}.
- One sub-module, if_id_reg, holds the decode register with load, hold and bubble controls. The FSM, PC and hold buffer sit in fetch_stage.

## Test plan
- Reset, then imem_req_ready=1 and a 1-cycle memory returning 32'h00A00093, 32'h00500113 -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles; instr_d=00A00093 with pc_d=0, then 00500113 with pc_d=4, pc_plus4_d=8.
- stall_d=1 for 3 cycles while a response arrives -> decode outputs frozen, response in the hold buffer, imem_req_valid=0; on release the held instruction appears with the next PC and no instruction is lost or duplicated.
- redirect=1 with redirect_pc=0x100 while in WAIT -> valid_d=0, instr_d=00000013 next cycle; the stale response is dropped; the next imem_addr=0x100.
- redirect and stall_d asserted together -> the flush wins: valid_d=0 and the hold buffer is cleared.
- imem_req_ready low for 4 cycles -> imem_addr holds steady, valid_d=0 bubbles; normal flow resumes on ready.
- Reset asserted while in WAIT -> outputs at reset values the next cycle; a late response is ignored; the first request goes to RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0,x0,0

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    // Sequential fetch address; wraps at the top of the 32-bit space.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response channel between fetch and imem.
interface fetch_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with flush (bubble), hold and load controls.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   bubble,
    input  logic   hold,
    input  logic   load,
    input  if_id_t d,
    output if_id_t q
);

    // Flush beats hold beats load; an idle cycle inserts a bubble but keeps the PCs.
    always_ff @(posedge clk) begin
        if (reset) begin
            q.instr    <= NOP_INSTR;
            q.pc       <= '0;
            q.pc_plus4 <= '0;
            q.valid    <= 1'b0;
        end else if (bubble) begin
            q.instr <= NOP_INSTR;
            q.valid <= 1'b0;
        end else if (!hold) begin
            if (load) begin
                q <= d;
            end else begin
                q.instr <= NOP_INSTR;
                q.valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the fetch PC, keeps at most one imem request in
// flight, and feeds the IF/ID register through a one-entry hold buffer.
//
// state | meaning
// RUN   | no request outstanding
// WAIT  | one request outstanding, its response is live
// DROP  | one request outstanding, its response is stale and gets discarded
module fetch_stage
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    fetch_if.master     imem,
    input  logic        stall_d,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc_f;
    logic [31:0]  req_pc;
    logic         hold_valid;
    logic [31:0]  hold_instr;
    logic [31:0]  hold_pc;

    logic         req_valid;
    logic         req_fire;
    logic         dec_free;
    logic         rsp_live;
    logic         rsp_to_hold;
    logic         dec_load;
    logic         dec_hold;
    if_id_t       dec_d;
    if_id_t       dec_q;

    assign dec_free    = !stall_d || !dec_q.valid;
    assign rsp_live    = (state == WAIT) && imem.imem_rsp_valid;
    assign rsp_to_hold = rsp_live && !dec_free && !redirect;

    // Request gating and next-state selection; redirect reroutes everything except DROP.
    always_comb begin
        state_nxt = state;
        req_valid = 1'b0;
        case (state)
            RUN:     req_valid = !hold_valid;
            WAIT:    req_valid = imem.imem_rsp_valid && !rsp_to_hold;
            default: req_valid = 1'b0;
        endcase
        if (reset) begin
            req_valid = 1'b0;
        end
        req_fire = req_valid && imem.imem_req_ready;

        case (state)
            RUN:     if (req_fire) state_nxt = WAIT;
            WAIT:    if (imem.imem_rsp_valid) state_nxt = req_fire ? WAIT : RUN;
            DROP:    if (imem.imem_rsp_valid) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase

        if (redirect && (state != DROP)) begin
            state_nxt = (req_fire || ((state == WAIT) && !imem.imem_rsp_valid)) ? DROP : RUN;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Fetch PC and the PC of the request in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f   <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            if (req_fire) begin
                req_pc <= pc_f;
            end
            if (redirect) begin
                pc_f <= redirect_pc;
            end else if (req_fire) begin
                pc_f <= pc_next(pc_f);
            end
        end
    end

    // Hold buffer: catches a response that lands while decode is stalled.
    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            hold_valid <= 1'b0;
        end else if (hold_valid && !stall_d) begin
            hold_valid <= 1'b0;
        end else if (rsp_to_hold) begin
            hold_valid <= 1'b1;
            hold_instr <= imem.imem_rsp_data;
            hold_pc    <= req_pc;
        end
    end

    // The held entry always goes first; no response can compete while it is full.
    assign dec_hold       = stall_d && dec_q.valid;
    assign dec_load       = hold_valid ? !stall_d : (rsp_live && dec_free);
    assign dec_d.instr    = hold_valid ? hold_instr : imem.imem_rsp_data;
    assign dec_d.pc       = hold_valid ? hold_pc : req_pc;
    assign dec_d.pc_plus4 = pc_next(dec_d.pc);
    assign dec_d.valid    = 1'b1;

    if_id_reg u_if_id (
        .clk    (clk),
        .reset  (reset),
        .bubble (redirect),
        .hold   (dec_hold),
        .load   (dec_load),
        .d      (dec_d),
        .q      (dec_q)
    );

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_addr      = pc_f;

    assign instr_d    = dec_q.instr;
    assign pc_d       = dec_q.pc;
    assign pc_plus4_d = dec_q.pc_plus4;
    assign valid_d    = dec_q.valid;

endmodule
